time_set_ctrl: RTL and testbench

Parametrised successor to the clock/alarm time-set state machine. Converts the set_time mode switch and the hours_set/mins_set buttons into registered one-cycle increment strobes for the hours and minutes fields of NUM_TGT targets (time, alarm, ...), plus a seconds run-enable. It adds target selection, hold-to-auto-repeat, and a both-buttons cancel lock. It sits between the debounced button inputs and the hour/minute counter blocks.

---
 rtl/time_set_pkg.sv | 32 +++
 rtl/hold_repeat_timer.sv | 65 ++++++
 rtl/time_set_ctrl.sv | 175 +++++++++++++++++
 tb/tb_time_set_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// -----------------------------------------------------------------------------
// time_set_pkg
// Shared definitions for the time/alarm set controller:
//   - state_t : controller state encoding (RUN, SET_IDLE, HR_HELD, MN_HELD, LOCK)
//   - btn_t   : sampled {hours_set, mins_set} button pair
//   - default parameter values for target count, counter width and repeat timing
// -----------------------------------------------------------------------------
package time_set_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_IDLE = 3'd1,
    HR_HELD  = 3'd2,
    MN_HELD  = 3'd3,
    LOCK     = 3'd4
  } state_t;

  // {hours_set, mins_set}
  typedef enum logic [1:0] {
    BTN_NONE = 2'b00,
    BTN_MN   = 2'b01,
    BTN_HR   = 2'b10,
    BTN_BOTH = 2'b11
  } btn_t;

  localparam int DEF_NUM_TGT    = 2;
  localparam int DEF_TGT_W      = 1;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_RPT_DELAY  = 50000;
  localparam int DEF_RPT_PERIOD = 12500;

endpackage : time_set_pkg

// File: rtl/hold_repeat_timer.sv
// -----------------------------------------------------------------------------
// hold_repeat_timer
// Hold counter and auto-repeat generator shared by the hours and minutes hold
// states. While 'run' is high the counter advances once per cycle; the first
// repeat fires when the counter reaches RPT_DELAY-1, later ones every
// RPT_PERIOD cycles. Dropping 'run' clears the counter and the repeat flag.
//
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   run       in   a single button is being held in a hold state
//   rpt_hit   out  combinational: a repeat strobe is due on this edge
//   rpt_seen  out  at least one repeat strobe has fired during this hold
// -----------------------------------------------------------------------------
module hold_repeat_timer
  import time_set_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic rpt_hit,
  output logic rpt_seen
);

  // A zero delay turns auto-repeat off entirely; DLY_LAST is then never used.
  localparam bit              RPT_EN   = (RPT_DELAY != 0);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] cnt;
  logic             seen_q;

  assign rpt_seen = seen_q;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    rpt_hit = 1'b0;
    if (run && RPT_EN) begin
      rpt_hit = seen_q ? (cnt == PER_LAST) : (cnt == DLY_LAST);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      seen_q <= 1'b0;
    end else if (!run) begin
      cnt    <= '0;
      seen_q <= 1'b0;
    end else if (rpt_hit) begin
      cnt    <= '0;
      seen_q <= 1'b1;
    end else if (cnt != CNT_MAX) begin
      // Saturate rather than wrap so a very long hold cannot re-trigger the delay.
      cnt <= cnt + 1'b1;
    end
  end

endmodule : hold_repeat_timer

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
// Turns the set_time mode switch and the debounced hours/minutes buttons into
// registered one-cycle increment strobes for NUM_TGT targets (time, alarm, ...)
// with hold-to-auto-repeat and a both-buttons cancel lock.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   set_time   in   1 = set mode, 0 = run mode
//   hours_set  in   hours button (debounced, synchronous, active-high)
//   mins_set   in   minutes button (debounced, synchronous, active-high)
//   tgt_sel    in   target to adjust, latched when a button press is detected
//   secs       out  seconds run-enable, 1 in run mode
//   hours      out  per-target hour increment strobe (one-hot or zero)
//   mins       out  per-target minute increment strobe (one-hot or zero)
//   busy       out  a press is being tracked (HR_HELD, MN_HELD, LOCK)
// -----------------------------------------------------------------------------
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int NUM_TGT    = DEF_NUM_TGT,
  parameter int TGT_W      = DEF_TGT_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               set_time,
  input  logic               hours_set,
  input  logic               mins_set,
  input  logic [TGT_W-1:0]   tgt_sel,
  output logic               secs,
  output logic [NUM_TGT-1:0] hours,
  output logic [NUM_TGT-1:0] mins,
  output logic               busy
);

  state_t             state, state_nxt;
  btn_t               btn;
  logic [TGT_W-1:0]   tgt_q, tgt_d;
  logic [NUM_TGT-1:0] tgt_oh;
  logic               timer_run;
  logic               rpt_hit;
  logic               rpt_seen;

  logic               secs_d;
  logic               busy_d;
  logic [NUM_TGT-1:0] hours_d;
  logic [NUM_TGT-1:0] mins_d;

  assign btn = btn_t'({hours_set, mins_set});

  // The timer only runs while exactly the button owning the hold state is down;
  // any other combination leaves the hold state and so clears the timer.
  assign timer_run = set_time &&
                     (((state == HR_HELD) && (btn == BTN_HR)) ||
                      ((state == MN_HELD) && (btn == BTN_MN)));

  hold_repeat_timer #(
    .CNT_W      (CNT_W),
    .RPT_DELAY  (RPT_DELAY),
    .RPT_PERIOD (RPT_PERIOD)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (timer_run),
    .rpt_hit  (rpt_hit),
    .rpt_seen (rpt_seen)
  );

  // One-hot decode of the latched target.
  always_comb begin
    tgt_oh = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      tgt_oh[i] = (int'(tgt_q) == i);
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: only control state is reset here; the design holds no memories.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      tgt_q <= '0;
      secs  <= 1'b0;
      busy  <= 1'b0;
      hours <= '0;
      mins  <= '0;
    end else begin
      state <= state_nxt;
      tgt_q <= tgt_d;
      secs  <= secs_d;
      busy  <= busy_d;
      hours <= hours_d;
      mins  <= mins_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    tgt_d     = tgt_q;
    if (!set_time) begin
      state_nxt = RUN;
    end else begin
      unique case (state)
        RUN: state_nxt = SET_IDLE;
        SET_IDLE: begin
          unique case (btn)
            BTN_NONE: state_nxt = SET_IDLE;
            BTN_HR:   state_nxt = HR_HELD;
            BTN_MN:   state_nxt = MN_HELD;
            BTN_BOTH: state_nxt = LOCK;
            default:  state_nxt = SET_IDLE;
          endcase
          if ((btn == BTN_HR) || (btn == BTN_MN)) begin
            // Out-of-range selections fall back to target 0.
            tgt_d = (int'(tgt_sel) < NUM_TGT) ? tgt_sel : '0;
          end
        end
        // Releasing the owning button ends the hold even if the other button
        // went down on the same edge; that press is picked up from SET_IDLE.
        HR_HELD: begin
          if (btn == BTN_BOTH)  state_nxt = LOCK;
          else if (!hours_set)  state_nxt = SET_IDLE;
        end
        MN_HELD: begin
          if (btn == BTN_BOTH)  state_nxt = LOCK;
          else if (!mins_set)   state_nxt = SET_IDLE;
        end
        LOCK: begin
          if (btn == BTN_NONE)  state_nxt = SET_IDLE;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (values registered on the next edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    secs_d  = (state_nxt == RUN);
    busy_d  = (state_nxt == HR_HELD) || (state_nxt == MN_HELD) || (state_nxt == LOCK);
    hours_d = '0;
    mins_d  = '0;
    if (set_time) begin
      unique case (state)
        HR_HELD: begin
          // A release only strobes when the hold never auto-repeated.
          if (btn == BTN_HR) begin
            if (rpt_hit) hours_d = tgt_oh;
          end else if (!hours_set && !rpt_seen) begin
            hours_d = tgt_oh;
          end
        end
        MN_HELD: begin
          if (btn == BTN_MN) begin
            if (rpt_hit) mins_d = tgt_oh;
          end else if (!mins_set && !rpt_seen) begin
            mins_d = tgt_oh;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : time_set_ctrl

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
// Scoreboard bench for time_set_ctrl. Instance dut_a uses RPT_DELAY=8,
// RPT_PERIOD=3, TGT_W=2; instance dut_b uses RPT_DELAY=0. Stimulus pushes the
// expected strobes (cycle, hours, mins) into a per-instance queue; monitors pop
// and compare whenever a strobe appears.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

  typedef struct {
    int         cyc;
    logic [1:0] hours;
    logic [1:0] mins;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       set_time, hours_set, mins_set;
  logic [1:0] tgt_sel;
  logic       secs;
  logic [1:0] hours, mins;
  logic       busy;

  logic       set_time_b, hours_set_b, mins_set_b;
  logic [1:0] tgt_sel_b;
  logic       secs_b;
  logic [1:0] hours_b, mins_b;
  logic       busy_b;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  time_set_ctrl #(
    .NUM_TGT(2), .TGT_W(2), .CNT_W(16), .RPT_DELAY(8), .RPT_PERIOD(3)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .set_time(set_time), .hours_set(hours_set),
    .mins_set(mins_set), .tgt_sel(tgt_sel), .secs(secs), .hours(hours),
    .mins(mins), .busy(busy)
  );

  time_set_ctrl #(
    .NUM_TGT(2), .TGT_W(2), .CNT_W(16), .RPT_DELAY(0), .RPT_PERIOD(3)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .set_time(set_time_b), .hours_set(hours_set_b),
    .mins_set(mins_set_b), .tgt_sel(tgt_sel_b), .secs(secs_b), .hours(hours_b),
    .mins(mins_b), .busy(busy_b)
  );

  task automatic check(string name, int actual, int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_a(int c, logic [1:0] h, logic [1:0] m);
    exp_t e;
    e.cyc = c; e.hours = h; e.mins = m;
    q_a.push_back(e);
  endtask

  task automatic push_b(int c, logic [1:0] h, logic [1:0] m);
    exp_t e;
    e.cyc = c; e.hours = h; e.mins = m;
    q_b.push_back(e);
  endtask

  // Monitors: sample registered outputs on the falling edge.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (reset_n && (hours != 2'b00 || mins != 2'b00)) begin
      check("a_exclusive", int'(hours != 2'b00 && mins != 2'b00), 0);
      if (q_a.size() == 0) begin
        check("a_unexpected_strobe", int'({hours, mins}), 0);
      end else begin
        e = q_a.pop_front();
        check("a_strobe_cycle", cyc, e.cyc);
        check("a_strobe_hours", int'(hours), int'(e.hours));
        check("a_strobe_mins", int'(mins), int'(e.mins));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (reset_n && (hours_b != 2'b00 || mins_b != 2'b00)) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_strobe", int'({hours_b, mins_b}), 0);
      end else begin
        e = q_b.pop_front();
        check("b_strobe_cycle", cyc, e.cyc);
        check("b_strobe_hours", int'(hours_b), int'(e.hours));
        check("b_strobe_mins", int'(mins_b), int'(e.mins));
      end
    end
  end

  initial begin : stim
    int e0;
    reset_n = 1'b0;
    set_time = 1'b0; hours_set = 1'b0; mins_set = 1'b0; tgt_sel = 2'd0;
    set_time_b = 1'b0; hours_set_b = 1'b0; mins_set_b = 1'b0; tgt_sel_b = 2'd0;

    // Reset state
    tick(2);
    check("reset_secs", int'(secs), 0);
    check("reset_hours", int'(hours), 0);
    check("reset_mins", int'(mins), 0);
    check("reset_busy", int'(busy), 0);

    reset_n = 1'b1;
    tick(1);
    check("run_secs_after_release", int'(secs), 1);
    tick(2);

    // Asynchronous reset mid-run clears outputs without a clock edge
    #2 reset_n = 1'b0;
    #1 check("async_reset_secs", int'(secs), 0);
    check("async_reset_busy", int'(busy), 0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check("secs_after_second_release", int'(secs), 1);

    // Enter set mode
    set_time = 1'b1;
    set_time_b = 1'b1;
    tick(1);
    check("set_mode_secs", int'(secs), 0);
    check("set_mode_busy", int'(busy), 0);

    // Short press on target 1: strobe the edge after release
    tgt_sel = 2'd1;
    hours_set = 1'b1;
    e0 = cyc + 1;
    push_a(e0 + 3, 2'b10, 2'b00);
    tick(3);
    check("short_press_busy", int'(busy), 1);
    hours_set = 1'b0;
    tick(3);
    check("short_press_idle", int'(busy), 0);

    // Auto-repeat on minutes, target 0; tgt_sel change mid-hold ignored
    tgt_sel = 2'd0;
    mins_set = 1'b1;
    e0 = cyc + 1;
    push_a(e0 + 8,  2'b00, 2'b01);
    push_a(e0 + 11, 2'b00, 2'b01);
    push_a(e0 + 14, 2'b00, 2'b01);
    push_a(e0 + 17, 2'b00, 2'b01);
    push_a(e0 + 20, 2'b00, 2'b01);
    tick(5);
    tgt_sel = 2'd1;
    tick(16);
    mins_set = 1'b0;
    tick(3);
    tgt_sel = 2'd0;

    // Cancel: hours then mins, release hours first
    hours_set = 1'b1;
    tick(2);
    mins_set = 1'b1;
    tick(2);
    check("cancel1_lock_busy", int'(busy), 1);
    hours_set = 1'b0;
    tick(2);
    check("cancel1_one_held_busy", int'(busy), 1);
    mins_set = 1'b0;
    tick(2);
    check("cancel1_released_busy", int'(busy), 0);

    // Cancel: release mins first
    hours_set = 1'b1;
    tick(2);
    mins_set = 1'b1;
    tick(2);
    mins_set = 1'b0;
    tick(2);
    check("cancel2_one_held_busy", int'(busy), 1);
    hours_set = 1'b0;
    tick(2);
    check("cancel2_released_busy", int'(busy), 0);

    // Mode exit mid-hold: no strobe, counter cleared
    hours_set = 1'b1;
    tick(5);
    set_time = 1'b0;
    hours_set = 1'b0;
    tick(1);
    check("mode_exit_secs", int'(secs), 1);
    check("mode_exit_busy", int'(busy), 0);
    set_time = 1'b1;
    tick(1);
    check("reenter_secs", int'(secs), 0);
    hours_set = 1'b1;
    e0 = cyc + 1;
    push_a(e0 + 8, 2'b01, 2'b00);
    tick(9);
    hours_set = 1'b0;
    tick(3);

    // Out-of-range target falls back to 0
    tgt_sel = 2'd3;
    mins_set = 1'b1;
    e0 = cyc + 1;
    push_a(e0 + 2, 2'b00, 2'b01);
    tick(2);
    mins_set = 1'b0;
    tick(3);

    // Repeat disabled: long hold strobes once, on release
    hours_set_b = 1'b1;
    e0 = cyc + 1;
    push_b(e0 + 100, 2'b01, 2'b00);
    tick(100);
    check("b_long_hold_busy", int'(busy_b), 1);
    hours_set_b = 1'b0;
    tick(3);
    check("b_after_release_busy", int'(busy_b), 0);

    check("a_scoreboard_drained", q_a.size(), 0);
    check("b_scoreboard_drained", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_time_set_ctrl
